// File: rtl/mod5_pkg.sv
// Shared types and constants for the mod-5 scheduler: FSM state encoding,
// word/residue widths and the residue update step.
package mod5_pkg;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned REM_W   = 3;
  localparam int unsigned DIVISOR = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // (2*r + b) mod DIVISOR; r < DIVISOR so a single conditional subtract suffices
  function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] r,
                                                 input logic             b);
    logic [REM_W:0] t;
    t = {r, b};
    if (t >= (REM_W+1)'(DIVISOR)) t = t - (REM_W+1)'(DIVISOR);
    return t[REM_W-1:0];
  endfunction

endpackage

// File: rtl/mod5_core.sv
// Serial residue engine: consumes one bit per enabled cycle, MSB first.
// Both outputs are registered, so bit_in never reaches div5 combinationally.
module mod5_core
  import mod5_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem,
  output logic             div5
);

  logic [REM_W-1:0] r_rem;
  logic             r_div5;
  logic [REM_W-1:0] w_next;

  assign w_next = rem_step(r_rem, bit_in);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_rem  <= '0;
      r_div5 <= 1'b1;
    end else if (en) begin
      r_rem  <= w_next;
      r_div5 <= (w_next == '0);
    end
  end

  assign rem  = r_rem;
  assign div5 = r_div5;

endmodule

// File: rtl/mod5_sched.sv
// Two-requester round-robin front end that serializes an accepted word into
// mod5_core and reports its residue mod 5 with a one-cycle response pulse.
module mod5_sched
  import mod5_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic              resp_div5,
  output logic [REM_W-1:0]  resp_rem,
  output logic              busy
);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt;
  logic [WORD_W-1:0] r_data;
  logic              r_id;
  logic              r_last_grant;
  logic              r_hold_id;
  logic [REM_W-1:0]  r_hold_rem;
  logic              r_hold_div5;

  logic              w_gnt0, w_gnt1, w_hs, w_done, w_bit;
  logic [REM_W-1:0]  w_rem;
  logic              w_div5;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        if (r_last_grant) w_gnt0 = 1'b1;
        else              w_gnt1 = 1'b1;
      end else if (req0_valid) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_hs = w_gnt0 | w_gnt1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == 3'd7) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_data       <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_hold_id    <= 1'b0;
      r_hold_rem   <= '0;
      r_hold_div5  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_data       <= w_gnt1 ? req1_data : req0_data;
        r_id         <= w_gnt1;
        r_last_grant <= w_gnt1;
        r_cnt        <= '0;
      end else if (r_state == SHIFT) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == DONE) begin
        r_hold_id   <= r_id;
        r_hold_rem  <= w_rem;
        r_hold_div5 <= w_div5;
      end
    end
  end

  // 7 - cnt on a 3-bit counter is its bitwise complement
  assign w_bit = r_data[~r_cnt];

  mod5_core u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_hs),
    .en     (r_state == SHIFT),
    .bit_in (w_bit),
    .rem    (w_rem),
    .div5   (w_div5)
  );

  // Response fields show live values in DONE and the captured copy otherwise
  assign w_done     = (r_state == DONE) && !rst;
  assign resp_valid = w_done;
  assign resp_id    = w_done ? r_id   : r_hold_id;
  assign resp_rem   = w_done ? w_rem  : r_hold_rem;
  assign resp_div5  = w_done ? w_div5 : r_hold_div5;
  assign busy       = (r_state != IDLE) && !rst;
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

endmodule

// File: tb/tb_mod5_sched.sv
// Directed self-checking bench for mod5_sched: reset, single words, boundary
// words, tie-break, fairness, mid-operation reset and post-handshake data hold.
module tb_mod5_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       resp_valid, resp_id, resp_div5, busy;
  logic [2:0] resp_rem;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_last = 0, hs_prev = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  mod5_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_div5  (resp_div5),
    .resp_rem   (resp_rem),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      hs_prev = hs_last;
      hs_last = cyc;
    end
    if (resp_valid) pulses = pulses + 1;
    cyc = cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Called in IDLE with valids already driven; returns at the response cycle.
  task automatic serve(input logic chg, input logic [7:0] nd0,
                       output logic [1:0] rdy, output int lat,
                       output logic id, output logic [2:0] rem, output logic dv);
    #1;
    rdy = {req1_ready, req0_ready};
    lat = 0;
    step();
    if (chg) req0_data = nd0;
    while (!resp_valid && lat < 20) begin
      step();
      lat++;
    end
    id  = resp_id;
    rem = resp_rem;
    dv  = resp_div5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    #1;
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checks++; if (resp_id !== 1'b0) begin failures++; $display("FAIL rst_resp_id got=%b exp=0", resp_id); end
    checks++; if (resp_rem !== 3'd0) begin failures++; $display("FAIL rst_resp_rem got=%0d exp=0", resp_rem); end
    checks++; if (resp_div5 !== 1'b0) begin failures++; $display("FAIL rst_resp_div5 got=%b exp=0", resp_div5); end
  endtask

  task automatic test_single();
    logic [1:0] rdy; int lat; logic id, dv; logic [2:0] rem;
    do_reset();
    req0_data = 8'h0A;
    req0_valid = 1'b1;
    serve(1'b0, 8'h00, rdy, lat, id, rem, dv);
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", rdy); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL single_latency got=%0d exp=8", lat); end
    checks++; if (id !== 1'b0) begin failures++; $display("FAIL single_id got=%b exp=0", id); end
    checks++; if (rem !== 3'd0) begin failures++; $display("FAIL single_rem got=%0d exp=0", rem); end
    checks++; if (dv !== 1'b1) begin failures++; $display("FAIL single_div5 got=%b exp=1", dv); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_done got=%b exp=1", busy); end
    req0_valid = 1'b0;
    step();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
    checks++; if (resp_div5 !== 1'b1) begin failures++; $display("FAIL single_div5_hold got=%b exp=1", resp_div5); end
  endtask

  task automatic test_boundary();
    logic [1:0] rdy; int lat; logic id, dv; logic [2:0] rem;
    do_reset();
    req1_data = 8'h07;
    req1_valid = 1'b1;
    serve(1'b0, 8'h00, rdy, lat, id, rem, dv);
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL b07_ready got=%b exp=10", rdy); end
    checks++; if (id !== 1'b1) begin failures++; $display("FAIL b07_id got=%b exp=1", id); end
    checks++; if (rem !== 3'd2) begin failures++; $display("FAIL b07_rem got=%0d exp=2", rem); end
    checks++; if (dv !== 1'b0) begin failures++; $display("FAIL b07_div5 got=%b exp=0", dv); end
    req1_valid = 1'b0;
    step();
    checks++; if (resp_rem !== 3'd2) begin failures++; $display("FAIL b07_rem_hold got=%0d exp=2", resp_rem); end
    checks++; if (resp_id !== 1'b1) begin failures++; $display("FAIL b07_id_hold got=%b exp=1", resp_id); end
    req0_data = 8'h00;
    req0_valid = 1'b1;
    serve(1'b0, 8'h00, rdy, lat, id, rem, dv);
    checks++; if (rem !== 3'd0 || dv !== 1'b1) begin failures++; $display("FAIL b00_result got=rem%0d/div%b exp=rem0/div1", rem, dv); end
    req0_valid = 1'b0;
    step();
    req0_data = 8'hFF;
    req0_valid = 1'b1;
    serve(1'b0, 8'h00, rdy, lat, id, rem, dv);
    checks++; if (rem !== 3'd0 || dv !== 1'b1) begin failures++; $display("FAIL bFF_result got=rem%0d/div%b exp=rem0/div1", rem, dv); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL bFF_latency got=%0d exp=8", lat); end
    req0_valid = 1'b0;
    step();
  endtask

  task automatic test_tie();
    logic [1:0] rdy; int lat; logic id, dv; logic [2:0] rem;
    do_reset();
    req0_data = 8'h14;
    req1_data = 8'h03;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    serve(1'b0, 8'h00, rdy, lat, id, rem, dv);
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL tie_first_ready got=%b exp=01", rdy); end
    checks++; if (id !== 1'b0 || rem !== 3'd0 || dv !== 1'b1) begin failures++; $display("FAIL tie_first got=id%b/rem%0d/div%b exp=id0/rem0/div1", id, rem, dv); end
    req0_valid = 1'b0;
    step();
    serve(1'b0, 8'h00, rdy, lat, id, rem, dv);
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL tie_second_ready got=%b exp=10", rdy); end
    checks++; if (id !== 1'b1 || rem !== 3'd3 || dv !== 1'b0) begin failures++; $display("FAIL tie_second got=id%b/rem%0d/div%b exp=id1/rem3/div0", id, rem, dv); end
    checks++; if (hs_last - hs_prev !== 10) begin failures++; $display("FAIL tie_spacing got=%0d exp=10", hs_last - hs_prev); end
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    logic [1:0] rdy; int lat; logic id, dv; logic [2:0] rem;
    int n0, n1;
    logic exp_id;
    n0 = 0;
    n1 = 0;
    do_reset();
    req0_data = 8'h0A;
    req1_data = 8'h07;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_id = (i % 2 == 1);
      serve(1'b0, 8'h00, rdy, lat, id, rem, dv);
      if (id) n1++; else n0++;
      checks++; if (id !== exp_id) begin failures++; $display("FAIL fair_id_%0d got=%b exp=%b", i, id, exp_id); end
      checks++; if (rem !== (exp_id ? 3'd2 : 3'd0)) begin failures++; $display("FAIL fair_rem_%0d got=%0d exp=%0d", i, rem, exp_id ? 2 : 0); end
      step();
    end
    checks++; if (n0 !== 3 || n1 !== 3) begin failures++; $display("FAIL fair_counts got=%0d/%0d exp=3/3", n0, n1); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    req0_data = 8'h0A;
    req0_valid = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    repeat (3) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    p0 = pulses;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
    repeat (12) step();
    checks++; if (pulses !== p0) begin failures++; $display("FAIL mid_no_pulse got=%0d exp=%0d", pulses, p0); end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL mid_tie_ready got=%b exp=01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_data_hold();
    logic [1:0] rdy; int lat; logic id, dv; logic [2:0] rem;
    do_reset();
    req0_data = 8'h0A;
    req0_valid = 1'b1;
    serve(1'b1, 8'h01, rdy, lat, id, rem, dv);
    checks++; if (rem !== 3'd0 || dv !== 1'b1) begin failures++; $display("FAIL hold_result got=rem%0d/div%b exp=rem0/div1", rem, dv); end
    req0_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_tie();
    test_fairness();
    test_reset_mid();
    test_data_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mod5_sched.md
MOD5_SCHED -- requirements
Module: mod5_sched

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have ports req0_valid / req1_valid  input  1  requester has a word pending.
REQ-004 SHALL have ports req0_data / req1_data  input  8  unsigned word to test, serialized MSB first.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  grant; handshake when valid and ready are both high at a rising edge.
REQ-006 SHALL have port resp_valid  output  1  one-cycle pulse marking a completed result.
REQ-007 SHALL have port resp_id  output  1  requester index of the completed word.
REQ-008 SHALL have port resp_div5  output  1  word is divisible by 5.
REQ-009 SHALL have port resp_rem  output  3  word mod 5, range 0..4.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 IDLE: SHALL assert ready to at most one requester, combinationally from valid and last_grant; no ready when neither valid.
REQ-013 Arbitration SHALL be round-robin: if both valid, grant the index not equal to last_grant; if only one valid, grant it.
REQ-014 On handshake, SHALL latch data and id, update last_grant, clear the residue and bit counter, and go to SHIFT.
REQ-015 SHIFT: each cycle SHALL feed bit data[7-cnt] to the residue engine, using r_next = (2*r + bit) mod 5, and increment the 3-bit counter.
REQ-016 SHALL leave SHIFT after exactly 8 shift edges (cnt wraps 7->0) and go to DONE.
REQ-017 DONE: SHALL drive resp_valid=1, resp_id=latched id, resp_rem=residue, resp_div5=(residue==0) for exactly one cycle, then return to IDLE.
REQ-018 Latency SHALL be fixed: resp_valid is high in the 9th cycle after the handshake edge (8 cycles after the edge).
REQ-019 Minimum handshake-to-handshake spacing SHALL be 10 cycles; no ready is asserted in SHIFT or DONE.
REQ-020 resp_id, resp_rem and resp_div5 SHALL hold their last values when resp_valid=0.
REQ-021 A requester that deasserts valid before the handshake SHALL lose nothing; no word is committed before the handshake.
REQ-022 Input data changes after the handshake SHALL NOT affect the result in flight.

Reset
REQ-023 On rst, SHALL set state=IDLE, cnt=0, residue=0, and last_grant=1 so that req0 wins the first tie.
REQ-024 On rst, SHALL set resp_valid=0, resp_id=0, resp_rem=0, resp_div5=0, busy=0, and both readys to 0 during the reset cycle.
REQ-025 rst during SHIFT or DONE SHALL abort the word with no response pulse; rst has priority over all other events.

Structure
REQ-026 Package mod5_pkg SHALL hold the state enum, WORD_W=8, REM_W=3, and DIVISOR=5.
REQ-027 The residue engine SHALL be sub-module mod5_core, with ports clk, rst, clr, en, bit_in, rem[2:0] and div5; mod5_sched instantiates exactly one.
REQ-028 The FSM and arbiter SHALL be in mod5_sched; only registers shall be in mod5_core, which has no combinational path from bit_in to div5.

Verification
REQ-029 Single request: req0 valid with 0x0A -> handshake, then 8 cycles later resp_valid=1, id=0, rem=0, div5=1.
REQ-030 Non-multiple: req1 valid with 0x07 -> id=1, rem=2, div5=0; boundary words 0x00 -> rem 0, div5 1 and 0xFF -> rem 0, div5 1.
REQ-031 Tie after reset: req0=0x14 and req1=0x03 both valid -> req0 served first (rem 0, div5 1), then req1 (rem 3, div5 0), with 10-cycle spacing.
REQ-032 Fairness: both requesters held valid for 6 words -> grants alternate 0,1,0,1,0,1 and no requester is starved.
REQ-033 Reset mid-operation: rst asserted at the 4th shift cycle -> no resp_valid pulse, busy=0 the next cycle, and the next tie grants req0.
REQ-034 Data hold: req0_data changed from 0x0A to 0x01 one cycle after the handshake -> result still rem=0, div5=1.
